// File: rtl/instr_fetch.sv
// S1C88 instruction fetch sequencer: opcode, extension and immediate bytes.
// Optional one-byte opcode prefetch buffer: define INSTR_FETCH_PREFETCH_EN.
module instr_fetch #(
  parameter int ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_ack,
  input  logic [7:0]            bus_data_in,
  output logic [7:0]            dec_opcode,
  output logic [7:0]            dec_opext,
  input  logic                  dec_need_opext,
  input  logic                  dec_need_imm,
  input  logic                  dec_imm_size,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            instr_opcode,
  output logic [7:0]            instr_opext,
  output logic [15:0]           instr_imm,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_EXT  = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_HI   = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic [7:0]            op_q, op_d;
  logic [7:0]            ext_q, ext_d;
  logic [15:0]           imm_q, imm_d;

  logic                  fetch_st;
  logic                  pf_req;
  logic                  beat;
  logic                  handoff;
  logic                  take;
  logic [7:0]            take_byte;
  logic [ADDR_WIDTH-1:0] take_pc;
  logic [2:0]            op_next;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [7:0]            pb_q, pb_d;
  logic                  pbv_q, pbv_d;
  logic [ADDR_WIDTH-1:0] pbpc_q, pbpc_d;

  assign pf_req = (state_q == S_HOLD) && !pbv_q;
`else
  assign pf_req = 1'b0;
`endif

  assign fetch_st = (state_q == S_OP) || (state_q == S_EXT) ||
                    (state_q == S_LO) || (state_q == S_HI);
  assign bus_req  = fetch_st || pf_req;
  assign bus_addr = pc_q;
  assign beat     = bus_req && bus_ack;
  assign handoff  = (state_q == S_HOLD) && instr_ready;

  // An opcode byte is consumed from the bus or, on handoff, the buffer.
  always_comb begin
    take      = 1'b0;
    take_byte = bus_data_in;
    take_pc   = pc_q;
    if (state_q == S_OP && beat) take = 1'b1;
`ifdef INSTR_FETCH_PREFETCH_EN
    if (handoff) begin
      if (pbv_q) begin
        take      = 1'b1;
        take_byte = pb_q;
        take_pc   = pbpc_q;
      end else if (beat) begin
        take = 1'b1;
      end
    end
`endif
  end

  assign dec_opcode = take ? take_byte : op_q;
  assign dec_opext  = (state_q == S_EXT && beat) ? bus_data_in : ext_q;

  assign op_next = dec_need_opext ? S_EXT :
                   dec_need_imm   ? S_LO  : S_HOLD;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    op_d    = op_q;
    ext_d   = ext_q;
    imm_d   = imm_q;
`ifdef INSTR_FETCH_PREFETCH_EN
    pb_d    = pb_q;
    pbv_d   = pbv_q;
    pbpc_d  = pbpc_q;
`endif
    if (beat) pc_d = pc_q + PC_ONE;

    unique case (state_q)
      S_IDLE: state_d = S_OP;
      S_OP: ;
      S_EXT: begin
        if (beat) begin
          ext_d   = bus_data_in;
          state_d = dec_need_imm ? S_LO : S_HOLD;
        end
      end
      S_LO: begin
        if (beat) begin
          imm_d[7:0] = bus_data_in;
          state_d    = dec_imm_size ? S_HI : S_HOLD;
        end
      end
      S_HI: begin
        if (beat) begin
          imm_d[15:8] = bus_data_in;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (handoff) state_d = S_OP;
`ifdef INSTR_FETCH_PREFETCH_EN
        if (handoff) begin
          pbv_d = 1'b0;
        end else if (beat) begin
          pb_d   = bus_data_in;
          pbv_d  = 1'b1;
          pbpc_d = pc_q;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      op_d    = take_byte;
      ipc_d   = take_pc;
      ext_d   = 8'h00;
      imm_d   = 16'h0000;
      state_d = op_next;
    end

    // Redirect drops any same-cycle beat; a handoff already happened.
    if (flush) begin
      state_d = S_OP;
      pc_d    = flush_pc;
      ipc_d   = ipc_q;
      op_d    = op_q;
      ext_d   = ext_q;
      imm_d   = imm_q;
`ifdef INSTR_FETCH_PREFETCH_EN
      pbv_d   = 1'b0;
      pb_d    = pb_q;
      pbpc_d  = pbpc_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      op_q    <= 8'h00;
      ext_q   <= 8'h00;
      imm_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      op_q    <= op_d;
      ext_q   <= ext_d;
      imm_q   <= imm_d;
    end
  end

`ifdef INSTR_FETCH_PREFETCH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_q   <= 8'h00;
      pbv_q  <= 1'b0;
      pbpc_q <= '0;
    end else begin
      pb_q   <= pb_d;
      pbv_q  <= pbv_d;
      pbpc_q <= pbpc_d;
    end
  end
`endif

  assign instr_valid  = (state_q == S_HOLD);
  assign instr_opcode = op_q;
  assign instr_opext  = ext_q;
  assign instr_imm    = imm_q;
  assign instr_pc     = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: bus/decoder stubs and a byte-stream model.
// Build with INSTR_FETCH_PREFETCH_EN defined to cover the prefetch variant.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_req;
  logic [23:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [7:0]  bus_data_in = 8'h00;
  logic [7:0]  dec_opcode, dec_opext;
  logic        dec_need_opext, dec_need_imm, dec_imm_size;
  logic        flush = 1'b0;
  logic [23:0] flush_pc = 24'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode, instr_opext;
  logic [15:0] instr_imm;
  logic [23:0] instr_pc;

  instr_fetch #(.ADDR_WIDTH(24), .RESET_PC(24'h000000)) dut (
    .clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_data_in(bus_data_in),
    .dec_opcode(dec_opcode), .dec_opext(dec_opext),
    .dec_need_opext(dec_need_opext), .dec_need_imm(dec_need_imm),
    .dec_imm_size(dec_imm_size),
    .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_opext(instr_opext),
    .instr_imm(instr_imm), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // Decoder stub: CE/CF take an extension byte that selects the immediate;
  // other opcodes: bit0 = has immediate, bit1 = 16-bit immediate.
  assign dec_need_opext = (dec_opcode == 8'hCE) || (dec_opcode == 8'hCF);
  assign dec_need_imm   = dec_need_opext ? dec_opext[2] : dec_opcode[0];
  assign dec_imm_size   = dec_need_opext ? dec_opext[6] : dec_opcode[1];

  typedef struct packed {
    logic [23:0] pc;
    logic [7:0]  op;
    logic [7:0]  ext;
    logic [15:0] imm;
  } exp_t;

  logic [7:0]  mem [0:16383];
  exp_t        exp_q [$];
  logic [23:0] model_pc;
  int          checks = 0;
  int          passes = 0;
  int          hs_cnt = 0;
  int          beats = 0;
  int          max_wait = 0;
  int          wleft = 0;
  bit          fixed_wait = 1'b0;

  function automatic exp_t observed();
    return {instr_pc, instr_opcode, instr_opext, instr_imm};
  endfunction

  task automatic push_next();
    exp_t e;
    logic ni, sz;
    e = '0;
    e.pc = model_pc;
    e.op = mem[model_pc[13:0]];
    model_pc++;
    if (e.op == 8'hCE || e.op == 8'hCF) begin
      e.ext = mem[model_pc[13:0]];
      model_pc++;
      ni = e.ext[2];
      sz = e.ext[6];
    end else begin
      ni = e.op[0];
      sz = e.op[1];
    end
    if (ni) begin
      e.imm[7:0] = mem[model_pc[13:0]];
      model_pc++;
      if (sz) begin
        e.imm[15:8] = mem[model_pc[13:0]];
        model_pc++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    bit   hold, bt;
    exp_t held, obs, want;
    if (bus_req) begin
      if (wleft == 0) bus_ack = 1'b1;
      else begin
        bus_ack = 1'b0;
        wleft--;
      end
    end else bus_ack = 1'b0;
    bus_data_in = mem[bus_addr[13:0]];
    obs = observed();
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) push_next();
      want = exp_q.pop_front();
      checks++;
      hs_cnt++;
      if (obs !== want)
        $display("FAIL handoff got %h want %h (pc op ext imm)", obs, want);
      else passes++;
    end
    if (flush) begin
      exp_q.delete();
      model_pc = flush_pc;
    end
    hold = instr_valid && !instr_ready && !flush;
    held = obs;
    bt = bus_req && bus_ack;
    @(posedge clk);
    #1;
    if (bt) begin
      beats++;
      wleft = fixed_wait ? max_wait : int'($urandom_range(max_wait, 0));
    end
    if (hold) begin
      checks++;
      if (!instr_valid || observed() !== held)
        $display("FAIL hold_stable got v=%b %h want v=1 %h",
                 instr_valid, observed(), held);
      else passes++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    instr_ready = 1'b0;
    bus_ack = 1'b0;
    exp_q.delete();
    model_pc = 24'h0;
    wleft = fixed_wait ? max_wait : 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    max_wait = 0;
    fixed_wait = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_req, bus_addr, instr_valid} !== {1'b0, 24'h0, 1'b0})
      $display("FAIL reset_bus got req=%b addr=%h v=%b want 0 000000 0",
               bus_req, bus_addr, instr_valid);
    else passes++;
    checks++;
    if ({observed(), dec_opcode, dec_opext} !== '0)
      $display("FAIL reset_fields got %h dec=%h/%h want 0",
               observed(), dec_opcode, dec_opext);
    else passes++;
    do_reset();
    tick();
    checks++;
    if ({bus_req, bus_addr, instr_valid} !== {1'b1, 24'h0, 1'b0})
      $display("FAIL first_fetch got req=%b addr=%h v=%b want 1 000000 0",
               bus_req, bus_addr, instr_valid);
    else passes++;
    tick();
    checks++;
    if ({instr_valid, observed()} !== {1'b1, 24'h0, 8'h00, 8'h00, 16'h0})
      $display("FAIL nop_instr got v=%b %h want 1 all-zero",
               instr_valid, observed());
    else passes++;
    checks++;
    if (bus_addr !== 24'h1)
      $display("FAIL nop_next_addr got %h want 000001", bus_addr);
    else passes++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 24'h1})
      $display("FAIL pf_next got v=%b pc=%h want 1 000001",
               instr_valid, instr_pc);
    else passes++;
`else
    checks++;
    if ({instr_valid, bus_req, bus_addr} !== {1'b0, 1'b1, 24'h1})
      $display("FAIL after_handoff got v=%b req=%b addr=%h want 0 1 000001",
               instr_valid, bus_req, bus_addr);
    else passes++;
`endif
  endtask

  task automatic test_ext_imm16();
    int n;
    mem[0] = 8'hCE; mem[1] = 8'hC4; mem[2] = 8'h34; mem[3] = 8'h12;
    mem[4] = 8'h00;
    max_wait = 0;
    fixed_wait = 1'b0;
    do_reset();
    beats = 0;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5 || beats !== 4)
      $display("FAIL ext_latency got cycles=%0d beats=%0d want 5 4", n, beats);
    else passes++;
    checks++;
    if (observed() !== {24'h0, 8'hCE, 8'hC4, 16'h1234})
      $display("FAIL ext_fields got %h want 000000 ce c4 1234", observed());
    else passes++;
    checks++;
    if (bus_addr !== 24'h4)
      $display("FAIL ext_next_addr got %h want 000004", bus_addr);
    else passes++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_wait_hold();
    int n;
    mem[0] = 8'h01; mem[1] = 8'h5A; mem[2] = 8'h00;
    max_wait = 2;
    fixed_wait = 1'b1;
    do_reset();
    n = 0;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 7)
      $display("FAIL wait_latency got %0d want 7", n);
    else passes++;
    checks++;
    if (observed() !== {24'h0, 8'h01, 8'h00, 16'h005A})
      $display("FAIL wait_fields got %h want 000000 01 00 005a", observed());
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifndef INSTR_FETCH_PREFETCH_EN
      checks++;
      if (bus_req !== 1'b0)
        $display("FAIL hold_no_bus got req=%b want 0", bus_req);
      else passes++;
`endif
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    fixed_wait = 1'b0;
    max_wait = 0;
  endtask

  task automatic test_flush_imm();
    int n;
    mem[0] = 8'h01; mem[1] = 8'h77; mem[2] = 8'h00;
    mem[14'h2000] = 8'h3C;
    mem[14'h3FFF] = 8'h01; mem[3] = 8'h00;
    max_wait = 0;
    do_reset();
    tick();
    tick();
    checks++;
    if ({bus_req, bus_addr, instr_valid} !== {1'b1, 24'h1, 1'b0})
      $display("FAIL imm_lo_phase got req=%b addr=%h v=%b want 1 000001 0",
               bus_req, bus_addr, instr_valid);
    else passes++;
    flush = 1'b1;
    flush_pc = 24'h2000;
    tick();
    flush = 1'b0;
    checks++;
    if ({bus_req, bus_addr, instr_valid} !== {1'b1, 24'h2000, 1'b0})
      $display("FAIL flush_redirect got req=%b addr=%h v=%b want 1 002000 0",
               bus_req, bus_addr, instr_valid);
    else passes++;
    tick();
    checks++;
    if ({instr_valid, observed()} !== {1'b1, 24'h2000, 8'h3C, 8'h00, 16'h0})
      $display("FAIL flush_target got v=%b %h want 1 002000 3c 00 0000",
               instr_valid, observed());
    else passes++;
    flush = 1'b1;
    flush_pc = 24'hFFFFFF;
    tick();
    flush = 1'b0;
    n = 0;
    while (!instr_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if ({instr_valid, observed(), bus_addr} !==
        {1'b1, 24'hFFFFFF, 8'h01, 8'h00, 16'h0001, 24'h000001})
      $display("FAIL pc_wrap got v=%b %h addr=%h want 1 ffffff 01 00 0001 000001",
               instr_valid, observed(), bus_addr);
    else passes++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    mem[0] = 8'hCE; mem[1] = 8'hC4; mem[2] = 8'h34; mem[3] = 8'h12;
    max_wait = 3;
    fixed_wait = 1'b1;
    do_reset();
    n = 0;
    while (!(bus_req && bus_addr == 24'h1) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (instr_opcode !== 8'hCE || bus_addr !== 24'h1)
      $display("FAIL reach_ext got op=%h addr=%h want ce 000001",
               instr_opcode, bus_addr);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_req, bus_addr, instr_valid} !== {1'b0, 24'h0, 1'b0})
      $display("FAIL async_reset_bus got req=%b addr=%h v=%b want 0 000000 0",
               bus_req, bus_addr, instr_valid);
    else passes++;
    checks++;
    if ({observed(), dec_opcode, dec_opext} !== '0)
      $display("FAIL async_reset_regs got %h dec=%h/%h want 0",
               observed(), dec_opcode, dec_opext);
    else passes++;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_pc = 24'h0;
    fixed_wait = 1'b0;
    max_wait = 0;
    wleft = 0;
    reset = 1'b0;
    tick();
    checks++;
    if ({bus_req, bus_addr} !== {1'b1, 24'h0})
      $display("FAIL restart_addr got req=%b addr=%h want 1 000000",
               bus_req, bus_addr);
    else passes++;
    n = 0;
    while (!instr_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (observed() !== {24'h0, 8'hCE, 8'hC4, 16'h1234})
      $display("FAIL restart_instr got %h want 000000 ce c4 1234", observed());
    else passes++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    bit         ev;
    int         ep;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom) & 8'hFE;
      if (b == 8'hCE) b = 8'h10;
      mem[i] = b;
    end
    max_wait = 0;
    fixed_wait = 1'b0;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
`ifdef INSTR_FETCH_PREFETCH_EN
      ev = (k >= 2);
      ep = k - 2;
`else
      ev = (k % 2 == 0);
      ep = k / 2 - 1;
`endif
      checks++;
      if (instr_valid !== ev || (ev && instr_pc !== 24'(ep)))
        $display("FAIL b2b_cycle%0d got v=%b pc=%h want v=%b pc=%h",
                 k, instr_valid, instr_pc, ev, 24'(ep));
      else passes++;
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_random();
    int         h0;
    logic [31:0] r;
    for (int i = 0; i < 16384; i++) begin
      r = $urandom;
      mem[i] = (r[12:10] == 3'd0) ? 8'hCE : r[7:0];
    end
    fixed_wait = 1'b0;
    max_wait = 0;
    do_reset();
    h0 = hs_cnt;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) max_wait = int'($urandom_range(2, 0));
      instr_ready = ($urandom_range(99, 0) < 70);
      flush = ($urandom_range(99, 0) < 2);
      if (flush)
        flush_pc = ($urandom_range(3, 0) == 0) ? 24'hFFFFFE
                                               : 24'($urandom_range(16383, 0));
      tick();
    end
    flush = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (hs_cnt - h0 < 200)
      $display("FAIL random_progress got %0d handoffs want >= 200", hs_cnt - h0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_ext_imm16();
    test_wait_hold();
    test_flush_imm();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
